// File: rtl/frac_lut4_cfg_writer.sv
// Serial configuration-chain writer for a fractured LUT4 (16 SRAM bits + mode bit).
// Optional readback verification pass is compiled in with FRAC_LUT4_CFG_READBACK_EN.
module frac_lut4_cfg_writer #(
    parameter int CHAIN_LEN = 17
) (
    input  logic                 prog_clk,
    input  logic                 prog_rst_n,
    input  logic                 cfg_valid,
    input  logic [CHAIN_LEN-1:0] cfg_word,
    output logic                 cfg_ready,
    output logic                 ccff_head,
    output logic                 shift_en,
    input  logic                 ccff_tail,
    output logic                 cfg_done,
    output logic                 cfg_err
);

    localparam int CW = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
`ifdef FRAC_LUT4_CFG_READBACK_EN
        S_VERIFY = 2'd2,
`endif
        S_DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_cnt;
    logic [CHAIN_LEN-1:0]   r_shadow;
    logic                   w_hs;
    logic                   w_last;
    logic                   w_busy;
    logic [CW-1:0]          w_idx;
    logic                   w_bit;

    assign w_hs   = cfg_valid && cfg_ready;
    assign w_last = (r_cnt == CW'(CHAIN_LEN - 1));
    // MSB leaves first: shift cycle k presents shadow[CHAIN_LEN-1-k]
    assign w_idx  = CW'(CHAIN_LEN - 1) - r_cnt;
    assign w_bit  = r_shadow[w_idx];

`ifdef FRAC_LUT4_CFG_READBACK_EN
    assign w_busy = (r_state == S_SHIFT) || (r_state == S_VERIFY);
`else
    assign w_busy = (r_state == S_SHIFT);
`endif

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_hs) w_next = S_SHIFT;
`ifdef FRAC_LUT4_CFG_READBACK_EN
            S_SHIFT:  if (w_last) w_next = S_VERIFY;
            S_VERIFY: if (w_last) w_next = S_DONE;
`else
            S_SHIFT:  if (w_last) w_next = S_DONE;
`endif
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        shift_en  = 1'b0;
        ccff_head = 1'b0;
        cfg_done  = 1'b0;
        case (r_state)
            S_IDLE:  cfg_ready = 1'b1;
            S_DONE:  cfg_done  = 1'b1;
            default: begin
                shift_en  = w_busy;
                ccff_head = w_busy & w_bit;
            end
        endcase
    end

    // Counter restarts at the terminal count so a verify pass reuses it; it never wraps past CHAIN_LEN-1
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_cnt <= '0;
        end else if (w_hs) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_shadow <= '0;
        end else if (w_hs) begin
            r_shadow <= cfg_word;
        end
    end

`ifdef FRAC_LUT4_CFG_READBACK_EN
    logic r_err;

    // The second pass pushes the same word in while the first copy emerges at the tail
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_err <= 1'b0;
        end else if ((r_state == S_VERIFY) && (ccff_tail != w_bit)) begin
            r_err <= 1'b1;
        end
    end

    assign cfg_err = r_err;
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
    assign cfg_err       = 1'b0;
`endif

endmodule
